mem_arbiter_nch: RTL and testbench

- Parametrised successor to the single fetch/LSB memory controller.
- Arbitrates NUM_CH requesters (fetcher, LSB, and later DMA or a second fetch port) onto the byte-serial RAM/IO bus using round-robin.
- Supports per-request size (byte/half/word) and a per-channel flush that aborts in-flight reads.
- Stalls IO writes while the UART buffer is full; freezes on rdy_in low.

---
 rtl/mem_arbiter_nch_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mem_arbiter_nch.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter_nch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_nch_pkg.sv
// Shared types and constants for the N-channel byte-serial memory arbiter.
// Size encodings, controller state enum, default IO base, size decode helper.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } arb_state_t;

  // Byte count for a size code, capped at the data path width.
  function automatic int unsigned size_bytes(
    input logic [1:0]  sz,
    input int unsigned cap
  );
    int unsigned n;
    case (sz)
      SZ_BYTE: n = 1;
      SZ_HALF: n = 2;
      default: n = 4;
    endcase
    if (n > cap) n = cap;
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer, with wrap.
// Ports: clk_in, rst_in (sync, active-low), req, adv -> gnt (one-hot), idx, any.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] req,
  input  logic              adv,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              any
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ptr_q <= '0;
    end else if (adv && any) begin
      ptr_q <= (int'(idx) == NUM_CH - 1) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel round-robin arbiter onto a byte-serial RAM/IO bus.
// Ports: per-channel req/we/size/addr/wdata in, ack/rdata out; mem_* bus.
module mem_arbiter_nch
  import mem_arb_pkg::*;
#(
  parameter int                NUM_CH     = 2,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = 'b01,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEF)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full,
  input  logic                     flush_in,
  input  logic [NUM_CH-1:0]        req_in,
  input  logic [NUM_CH-1:0]        we_in,
  input  logic [2*NUM_CH-1:0]      size_in,
  input  logic [ADDR_W*NUM_CH-1:0] addr_in,
  input  logic [DATA_W*NUM_CH-1:0] wdata_in,
  output logic [NUM_CH-1:0]        ack_out,
  output logic [DATA_W-1:0]        rdata_out
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t state_q, state_d;

  logic [NUM_CH-1:0] req_ok, gnt, gnt_q;
  logic [IW-1:0]     g_idx;
  logic              g_any, take;

  logic              g_we;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [CW-1:0]     g_n;

  logic              we_q, cap_q;
  logic [CW-1:0]     n_q, k_q;
  logic [ADDR_W-1:0] addr_q, cur_a;
  logic [DATA_W-1:0] wdata_q, rdata_q, rdata_cap;
  logic [7:0]        wbyte;

  logic issue, stall, abort, fire;

  // A flushable read is masked out of arbitration while flush is high.
  always_comb begin
    req_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_ok[i] = req_in[i]
                & ~(flush_in & FLUSH_MASK[i] & ~we_in[i]);
    end
  end

  assign take = (state_q == ST_IDLE) & rdy_in & g_any;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_rr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .req    (req_ok),
    .adv    (take),
    .gnt    (gnt),
    .idx    (g_idx),
    .any    (g_any)
  );

  always_comb begin
    g_we    = we_in[g_idx];
    g_size  = size_in[2*int'(g_idx) +: 2];
    g_addr  = addr_in[ADDR_W*int'(g_idx) +: ADDR_W];
    g_wdata = wdata_in[DATA_W*int'(g_idx) +: DATA_W];
    g_n     = CW'(size_bytes(g_size, NB));
  end

  assign cur_a = addr_q + ADDR_W'(k_q);
  assign issue = (state_q == ST_XFER)
               | ((state_q == ST_DONE) & we_q);
  assign stall = we_q & io_buffer_full & (cur_a >= IO_BASE);
  assign abort = flush_in & ~we_q & (|(gnt_q & FLUSH_MASK))
               & (state_q != ST_IDLE);
  assign fire  = (state_q == ST_DONE) & rdy_in & ~abort & ~stall;

  // k_q runs one ahead of the byte being captured, so the byte
  // landing on mem_din this cycle belongs at index k_q-1.
  always_comb begin
    rdata_cap = rdata_q;
    wbyte     = '0;
    for (int b = 0; b < NB; b++) begin
      if (k_q == CW'(b + 1)) rdata_cap[8*b +: 8] = mem_din;
      if (k_q == CW'(b))     wbyte = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Reads finish in DONE (final capture); writes issue their last byte
  // in DONE, so a write acks together with its final bus write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take)
          state_d = (g_we && g_n == CW'(1)) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        if (rdy_in) begin
          if (abort)
            state_d = ST_IDLE;
          else if (we_q) begin
            if (!stall && k_q == n_q - CW'(2)) state_d = ST_DONE;
          end else if (k_q == n_q - CW'(1))
            state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!rdy_in) begin
          if (!we_q) state_d = ST_XFER;
        end else if (abort || !stall)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      gnt_q   <= '0;
      we_q    <= 1'b0;
      n_q     <= '0;
      k_q     <= '0;
      cap_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            gnt_q   <= gnt;
            we_q    <= g_we;
            n_q     <= g_n;
            addr_q  <= g_addr;
            wdata_q <= g_wdata;
            rdata_q <= '0;
            k_q     <= '0;
            cap_q   <= 1'b0;
          end
        end
        ST_XFER: begin
          if (!rdy_in) begin
            // Capture lost: step back so the byte is fetched again.
            if (cap_q) begin
              k_q   <= k_q - CW'(1);
              cap_q <= 1'b0;
            end
          end else if (abort) begin
            k_q   <= '0;
            cap_q <= 1'b0;
          end else if (we_q) begin
            if (!stall) k_q <= k_q + CW'(1);
          end else begin
            if (cap_q) rdata_q <= rdata_cap;
            k_q   <= k_q + CW'(1);
            cap_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!rdy_in) begin
            if (!we_q) begin
              k_q   <= k_q - CW'(1);
              cap_q <= 1'b0;
            end
          end else if (abort || !stall) begin
            k_q   <= '0;
            cap_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_a     = issue ? cur_a : '0;
    mem_wr    = issue & we_q & rdy_in & ~stall;
    mem_dout  = (issue & we_q) ? wbyte : '0;
    ack_out   = fire ? gnt_q : '0;
    rdata_out = (fire & ~we_q) ? rdata_cap : '0;
  end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch with a one-cycle-latency RAM model.
// Checks reset, round-robin, IO stall, flush, freeze and mid-transfer reset.
module tb_mem_arbiter_nch;

  logic        clk = 1'b0;
  logic        rst_n, rdy, iofull, flush, preload;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  req, we, ack;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] ram [0:1023];
  int         wr_cnt [0:1023];

  always #5 clk = ~clk;

  mem_arbiter_nch #(
    .NUM_CH     (2),
    .ADDR_W     (32),
    .DATA_W     (32),
    .FLUSH_MASK (2'b01),
    .IO_BASE    (32'h0003_0000)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rdy_in         (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (iofull),
    .flush_in       (flush),
    .req_in         (req),
    .we_in          (we),
    .size_in        (size),
    .addr_in        (addr),
    .wdata_in       (wdata),
    .ack_out        (ack),
    .rdata_out      (rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) begin
        ram[i]    <= 8'h00;
        wr_cnt[i] <= 0;
      end
      ram[256] <= 8'h11;
      ram[257] <= 8'h22;
      ram[258] <= 8'h33;
      ram[259] <= 8'h44;
    end else if (mem_wr) begin
      ram[mem_a[9:0]]    <= mem_dout;
      wr_cnt[mem_a[9:0]] <= wr_cnt[mem_a[9:0]] + 1;
    end
    mem_din <= ram[mem_a[9:0]];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
    we[ch]          = w;
    size[2*ch +: 2] = sz;
    addr[32*ch +: 32]  = a;
    wdata[32*ch +: 32] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nack;
    int last;
    rst_n = 1'b0; rdy = 1'b1; iofull = 1'b0; flush = 1'b0;
    req = '0; we = '0; size = '0; addr = '0; wdata = '0;
    preload = 1'b1;
    tick;
    tick;
    preload = 1'b0;
    #2;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);

    // ch1 word read at 0x100
    tick; rst_n = 1'b1;
    tick;
    set_ch(1, 1'b0, 2'd2, 32'h100, 32'h0);
    req[1] = 1'b1;
    #2 chk("s1_grant_ack", ack, 0);
    for (int k = 0; k < 4; k++) begin
      tick; #2;
      chk($sformatf("s1_addr%0d", k), mem_a, 32'h100 + k);
      chk($sformatf("s1_wr%0d", k), mem_wr, 0);
    end
    tick; #2;
    chk("s1_ack", ack, 2'b10);
    chk("s1_rdata", rdata, 32'h4433_2211);
    req[1] = 1'b0;
    tick; #2 chk("s1_after", ack, 0);

    // both channels request continuously
    set_ch(0, 1'b1, 2'd1, 32'h200, 32'hBEEF);
    set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
    tick;
    req = 2'b11;
    nack = 0;
    last = -1;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      tick; #2;
      if (ack != 2'b00) begin
        chk($sformatf("s2_ack%0d", nack), ack,
            (nack % 2 == 0) ? 2'b01 : 2'b10);
        if (ack == 2'b10) chk("s2_rdata", rdata, 32'h22);
        if (nack > 0) chk($sformatf("s2_gap%0d", nack), c - last, 3);
        last = c;
        nack++;
      end
    end
    req = 2'b00;
    chk("s2_nacks", nack, 4);
    tick;
    tick; #2;
    chk("s2_mem", {ram[513], ram[512]}, 16'hBEEF);

    // IO write stalled by a full UART buffer
    set_ch(1, 1'b1, 2'd0, 32'h0003_0000, 32'h41);
    req[1] = 1'b1;
    iofull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; #2;
      chk($sformatf("s3_stall_wr%0d", k), mem_wr, 0);
      chk($sformatf("s3_stall_ack%0d", k), ack, 0);
    end
    chk("s3_addr", mem_a, 32'h0003_0000);
    tick;
    iofull = 1'b0;
    #2;
    chk("s3_wr", mem_wr, 1);
    chk("s3_dout", mem_dout, 8'h41);
    chk("s3_ack", ack, 2'b10);
    req[1] = 1'b0;
    tick; #2;
    chk("s3_wr_after", mem_wr, 0);
    chk("s3_wr_cnt", wr_cnt[0], 1);

    // ch0 read flushed at byte 2, ch1 served afterwards
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
    req[0] = 1'b1;
    tick; #2 chk("s4_addr0", mem_a, 32'h100);
    tick;
    tick;
    flush  = 1'b1;
    req[0] = 1'b0;
    #2 chk("s4_flush_ack", ack, 0);
    tick;
    flush = 1'b0;
    set_ch(1, 1'b0, 2'd0, 32'h102, 32'h0);
    req[1] = 1'b1;
    #2;
    chk("s4_idle_addr", mem_a, 0);
    chk("s4_idle_ack", ack, 0);
    tick; #2 chk("s4_ch1_addr", mem_a, 32'h102);
    tick; #2;
    chk("s4_ch1_ack", ack, 2'b10);
    chk("s4_ch1_rdata", rdata, 32'h33);
    req[1] = 1'b0;

    // ch1 word write with rdy low for two cycles at byte 1
    tick;
    set_ch(1, 1'b1, 2'd2, 32'h300, 32'hA1B2_C3D4);
    req[1] = 1'b1;
    tick; #2;
    chk("s5_b0_wr", mem_wr, 1);
    chk("s5_b0_dout", mem_dout, 8'hD4);
    tick;
    rdy = 1'b0;
    #2 chk("s5_frz0_wr", mem_wr, 0);
    tick; #2;
    chk("s5_frz1_wr", mem_wr, 0);
    chk("s5_frz1_ack", ack, 0);
    tick;
    rdy = 1'b1;
    #2;
    chk("s5_b1_addr", mem_a, 32'h301);
    chk("s5_b1_dout", mem_dout, 8'hC3);
    chk("s5_b1_wr", mem_wr, 1);
    tick; #2 chk("s5_b2_ack", ack, 0);
    tick; #2;
    chk("s5_ack", ack, 2'b10);
    chk("s5_b3_addr", mem_a, 32'h303);
    chk("s5_b3_dout", mem_dout, 8'hA1);
    req[1] = 1'b0;
    tick;
    tick; #2;
    chk("s5_mem", {ram[771], ram[770], ram[769], ram[768]}, 32'hA1B2_C3D4);
    chk("s5_b1_cnt", wr_cnt[769], 1);

    // reset in the middle of a ch0 read
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
    req[0] = 1'b1;
    tick;
    tick;
    rst_n = 1'b0;
    tick; #2;
    chk("s6_rst_addr", mem_a, 0);
    chk("s6_rst_wr", mem_wr, 0);
    chk("s6_rst_ack", ack, 0);
    chk("s6_rst_rdata", rdata, 0);
    set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0);
    req   = 2'b11;
    rst_n = 1'b1;
    tick; #2 chk("s6_first_addr", mem_a, 32'h100);
    tick; #2;
    chk("s6_ack0", ack, 2'b01);
    chk("s6_rdata0", rdata, 32'h11);
    req[0] = 1'b0;
    tick;
    tick;
    tick; #2;
    chk("s6_ack1", ack, 2'b10);
    chk("s6_rdata1", rdata, 32'h22);
    req = 2'b00;
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
